// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and size defaults for the sequential subtractor
//
// Contents:
//   WIDTH_DEF / SLICE_DEF : default operand width and bits processed per cycle
//   nslice()              : number of slices for a given width/slice pair
//   sub_state_t           : controller states IDLE -> CALC -> DONE
package sub_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SLICE_DEF = 8;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    localparam int NSLICE_DEF = nslice(WIDTH_DEF, SLICE_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/seq_subtractor_if.sv
// rtl/seq_subtractor_if.sv - operand/result handshake bundle of the sequential subtractor
//
// Signals:
//   in_valid / in_ready   : operand handshake (source -> subtractor)
//   a, b, bin             : minuend, subtrahend, borrow in
//   out_valid / out_ready : result handshake (subtractor -> consumer)
//   diff, bo, OF          : difference, unsigned borrow out, signed overflow
// Modports:
//   master : operand source / result consumer side
//   slave  : the subtractor itself
interface seq_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bo;
    logic             OF;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bo, OF
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bo, OF
    );

endinterface

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational W-bit subtract-with-borrow slice
//
// Ports:
//   x    in  W  minuend slice
//   y    in  W  subtrahend slice
//   bi   in  1  borrow into this slice
//   d    out W  x - y - bi (mod 2^W)
//   bo_o out 1  borrow out of this slice (x < y + bi)
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo_o
);

    logic [W:0] full;

    // One extra bit: the result can go as low as -2^W, whose top bit
    // in W+1 bits is set exactly when the slice needs to borrow.
    always_comb begin
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        d    = full[W-1:0];
        bo_o = full[W];
    end

endmodule

// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - multi-cycle two's-complement subtractor, one slice per clock
//
// Computes diff = a - b - bin, rippling a registered borrow from the least
// significant slice to the most significant one, one SLICE-bit chunk per cycle.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous, active-high reset
//   bus  seq_subtractor_if.slave
//        in_valid/in_ready, a, b, bin     operand handshake
//        out_valid/out_ready, diff, bo, OF result handshake
//
// Parameters:
//   WIDTH  operand/result width, exact multiple of SLICE
//   SLICE  bits processed per CALC cycle
//
// Build option:
//   SUB_SAT_EN  when defined, diff saturates to the signed max/min on overflow
module seq_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    seq_subtractor_if.slave     bus
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_width_check
            $fatal(1, "seq_subtractor: WIDTH must be an exact multiple of SLICE");
        end
    endgenerate

    sub_state_t state;
    sub_state_t state_nxt;

    // Captured operands and the partially built result.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_r;
    logic             borrow_r;
    logic [IDX_W-1:0] idx_r;

    // Presented result; only ever written on the CALC->DONE edge.
    logic [WIDTH-1:0] diff_r;
    logic             bo_r;
    logic             of_r;

    // Control decoded from the state.
    logic in_ready_c;
    logic out_valid_c;
    logic accept;
    logic finish;
    logic last;

    // Slice datapath.
    logic [SLICE-1:0] x_s;
    logic [SLICE-1:0] y_s;
    logic [SLICE-1:0] d_s;
    logic             bo_s;
    logic [WIDTH-1:0] work_nxt;
    logic             of_nxt;
    logic [WIDTH-1:0] res_out;

    assign last = (idx_r == LAST_IDX);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slice datapath: one shared slice subtractor, operands muxed by idx
    // ------------------------------------------------------------------
    always_comb begin
        x_s = a_r[idx_r*SLICE +: SLICE];
        y_s = b_r[idx_r*SLICE +: SLICE];
    end

    sub_slice #(
        .W (SLICE)
    ) u_slice (
        .x    (x_s),
        .y    (y_s),
        .bi   (borrow_r),
        .d    (d_s),
        .bo_o (bo_s)
    );

    // work_nxt is the working register with the current slice merged in; on
    // the last slice it is the complete wrapped difference, so overflow and
    // the presented result are derived from it in the same cycle.
    always_comb begin
        work_nxt                     = work_r;
        work_nxt[idx_r*SLICE +: SLICE] = d_s;
        of_nxt = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (work_nxt[WIDTH-1] ^ a_r[WIDTH-1]);
`ifdef SUB_SAT_EN
        // Overflow can only push a positive minuend negative or vice versa,
        // so the minuend sign picks which rail to clamp to.
        if (of_nxt) begin
            res_out = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_out = work_nxt;
        end
`else
        res_out = work_nxt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            work_r   <= '0;
            borrow_r <= 1'b0;
            idx_r    <= '0;
            diff_r   <= '0;
            bo_r     <= 1'b0;
            of_r     <= 1'b0;
        end else begin
            if (accept) begin
                a_r      <= bus.a;
                b_r      <= bus.b;
                borrow_r <= bus.bin;
                work_r   <= '0;
                idx_r    <= '0;
            end else if (state == CALC) begin
                work_r   <= work_nxt;
                borrow_r <= bo_s;
                if (finish) begin
                    // Return idx to 0 explicitly so non-power-of-two slice
                    // counts never leave it pointing past the operand.
                    idx_r  <= '0;
                    diff_r <= res_out;
                    bo_r   <= bo_s;
                    of_r   <= of_nxt;
                end else begin
                    idx_r  <= idx_r + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_r;
    assign bus.bo        = bo_r;
    assign bus.OF        = of_r;

endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - self-checking bench for seq_subtractor
module tb_seq_subtractor;
    import sub_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_subtractor_if #(.WIDTH(W)) bus ();

    seq_subtractor #(.WIDTH(W), .SLICE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain wide arithmetic on the whole operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         output logic [31:0] d, output logic bo, output logic of);
        logic [63:0] full;
        full = {32'b0, a} - {32'b0, b} - {63'b0, bin};
        d    = full[31:0];
        bo   = ({32'b0, a} < ({32'b0, b} + {63'b0, bin}));
        of   = (a[31] ^ b[31]) & (d[31] ^ a[31]);
`ifdef SUB_SAT_EN
        if (of) d = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    endtask

    // Issue one operation and wait for its result; leaves out_ready low so the
    // caller decides when to drain. Called and returns at 1 time unit past a rising edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         output logic [31:0] d, output logic bo, output logic of,
                         output int lat, output logic ok);
        int n;
        ok = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) ok = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 50) ok = 1'b0;
        d  = bus.diff;
        bo = bus.bo;
        of = bus.OF;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.diff !== 32'h0) begin errors++; $display("FAIL reset_diff: got %h expected 00000000", bus.diff); end
        checks++; if ({bus.bo, bus.OF} !== 2'b00) begin errors++; $display("FAIL reset_flags: got bo=%b OF=%b expected 0 0", bus.bo, bus.OF); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va   [5];
        logic [31:0] vb   [5];
        logic        vbin [5];
        logic [31:0] ed   [5];
        logic        ebo  [5];
        logic        eof  [5];
        logic [31:0] d;
        logic        bo, of, ok;
        int          lat;
        va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000; vbin[0] = 1'b0; ed[0] = 32'h0000_0000; ebo[0] = 1'b0; eof[0] = 1'b0;
        va[1] = 32'h0000_0100; vb[1] = 32'h0000_0000; vbin[1] = 1'b1; ed[1] = 32'h0000_00FF; ebo[1] = 1'b0; eof[1] = 1'b0;
        va[2] = 32'h0000_0000; vb[2] = 32'h0000_0001; vbin[2] = 1'b0; ed[2] = 32'hFFFF_FFFF; ebo[2] = 1'b1; eof[2] = 1'b0;
        va[3] = 32'h8000_0000; vb[3] = 32'h0000_0001; vbin[3] = 1'b0; ebo[3] = 1'b0; eof[3] = 1'b1;
        va[4] = 32'h7FFF_FFFF; vb[4] = 32'hFFFF_FFFF; vbin[4] = 1'b0; ebo[4] = 1'b1; eof[4] = 1'b1;
`ifdef SUB_SAT_EN
        ed[3] = 32'h8000_0000;
        ed[4] = 32'h7FFF_FFFF;
`else
        ed[3] = 32'h7FFF_FFFF;
        ed[4] = 32'h8000_0000;
`endif
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vbin[i], d, bo, of, lat, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dir%0d_timeout: handshake did not complete", i); end
            checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (d !== ed[i]) begin errors++; $display("FAIL dir%0d_diff: got %h expected %h", i, d, ed[i]); end
            checks++; if (bo !== ebo[i]) begin errors++; $display("FAIL dir%0d_bo: got %b expected %b", i, bo, ebo[i]); end
            checks++; if (of !== eof[i]) begin errors++; $display("FAIL dir%0d_OF: got %b expected %b", i, of, eof[i]); end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d, md;
        logic        bin, bo, of, mbo, mof, ok;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            bin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: b = a;
                1: a = {1'b1, 31'($urandom_range(0, 3))};
                2: a = {1'b0, 31'h7FFF_FFF0 | 31'($urandom_range(0, 15))};
                default: ;
            endcase
            model(a, b, bin, md, mbo, mof);
            do_op(a, b, bin, d, bo, of, lat, ok);
            checks++; if (ok !== 1'b1 || d !== md || bo !== mbo || of !== mof)
            begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h bin=%b got diff=%h bo=%b OF=%b ok=%b expected diff=%h bo=%b OF=%b",
                         i, a, b, bin, d, bo, of, ok, md, mbo, mof);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, md;
        logic        bo, of, mbo, mof, ok;
        int          lat;
        model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, md, mbo, mof);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, d, bo, of, lat, ok);
        checks++; if (ok !== 1'b1 || d !== md) begin errors++; $display("FAIL bp_result: got %h ok=%b expected %h", d, ok, md); end
        // A competing operand during DONE must be ignored.
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'h0000_0001;
        bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL bp_hold%0d_ctrl: got out_valid=%b in_ready=%b expected 1 0", i, bus.out_valid, bus.in_ready); end
            checks++; if (bus.diff !== md || bus.bo !== mbo || bus.OF !== mof)
            begin errors++; $display("FAIL bp_hold%0d_data: got %h %b %b expected %h %b %b", i, bus.diff, bus.bo, bus.OF, md, mbo, mof); end
        end
        bus.in_valid = 1'b0;
        release_out();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        begin errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready); end
        model(32'h0000_0010, 32'h0000_0020, 1'b0, md, mbo, mof);
        do_op(32'h0000_0010, 32'h0000_0020, 1'b0, d, bo, of, lat, ok);
        checks++; if (ok !== 1'b1 || d !== md || bo !== mbo || of !== mof)
        begin errors++; $display("FAIL bp_next_op: got %h %b %b expected %h %b %b", d, bo, of, md, mbo, mof); end
        release_out();
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] d, md;
        logic        bo, of, mbo, mof, ok;
        int          lat;
        // The previous result (0xFFFFFFF0) is nonzero, so a cleared diff is observable.
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0BAD_F00D;
        bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        begin errors++; $display("FAIL rst_mid_ctrl: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.diff !== 32'h0 || bus.bo !== 1'b0 || bus.OF !== 1'b0)
        begin errors++; $display("FAIL rst_mid_data: got %h %b %b expected 00000000 0 0", bus.diff, bus.bo, bus.OF); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        model(32'h0000_0001, 32'h0000_0002, 1'b1, md, mbo, mof);
        do_op(32'h0000_0001, 32'h0000_0002, 1'b1, d, bo, of, lat, ok);
        checks++; if (ok !== 1'b1 || lat != 4 || d !== md || bo !== mbo || of !== mof)
        begin errors++; $display("FAIL rst_mid_after: got %h %b %b lat=%0d expected %h %b %b lat=4", d, bo, of, lat, md, mbo, mof); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [31:0] md;
        logic        mbo, mof;
        int          n_done;
        model(32'hCAFE_0000, 32'h0000_BABE, 1'b1, md, mbo, mof);
        bus.a = 32'hCAFE_0000;
        bus.b = 32'h0000_BABE;
        bus.bin = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin
                n_done++;
                checks++; if (bus.diff !== md || bus.bo !== mbo || bus.OF !== mof)
                begin errors++; $display("FAIL b2b_data%0d: got %h %b %b expected %h %b %b", n_done, bus.diff, bus.bo, bus.OF, md, mbo, mof); end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        // One operation per NSLICE+2 = 6 cycles over 30 cycles.
        checks++; if (n_done != 5) begin errors++; $display("FAIL b2b_throughput: got %0d results expected 5", n_done); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
